// File: rtl/hazard_control.sv
// hazard_control: forwarding select, load-use stall and flush kill for the five-stage core.
// Define HAZARD_PERF_EN to add the stall/flush event counters.
module hazard_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_d,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic        rs1_used_d,
  input  logic        rs2_used_d,
  input  logic [4:0]  rd_d,
  input  logic        reg_wr_d,
  input  logic        load_d,
  input  logic        flush,
  output logic [3:0]  fwd_sel_e,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e
`ifdef HAZARD_PERF_EN
  ,
  input  logic        perf_clr,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd;
    logic       reg_wr;
    logic       load;
  } e_rec_t;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_wr;
    logic       load;
  } m_rec_t;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_wr;
  } w_rec_t;
  e_rec_t r_e;
  m_rec_t r_m;
  w_rec_t r_w;
  logic w_lu, w_m_a, w_m_b, w_w_a, w_w_b;
  assign w_lu = valid_d && r_e.valid && r_e.load && r_e.reg_wr && r_e.rd != 5'd0 &&
                ((rs1_used_d && rs1_d == r_e.rd) || (rs2_used_d && rs2_d == r_e.rd));
  // a bubble in E never forwards; a load in M falls through to W
  assign w_m_a = r_e.valid && r_e.rs1_used && r_e.rs1 != 5'd0 && r_m.valid && r_m.reg_wr && !r_m.load && r_m.rd == r_e.rs1;
  assign w_m_b = r_e.valid && r_e.rs2_used && r_e.rs2 != 5'd0 && r_m.valid && r_m.reg_wr && !r_m.load && r_m.rd == r_e.rs2;
  assign w_w_a = r_e.valid && r_e.rs1_used && r_e.rs1 != 5'd0 && r_w.valid && r_w.reg_wr && r_w.rd == r_e.rs1;
  assign w_w_b = r_e.valid && r_e.rs2_used && r_e.rs2 != 5'd0 && r_w.valid && r_w.reg_wr && r_w.rd == r_e.rs2;
  assign fwd_sel_e = {w_m_b ? 2'd1 : w_w_b ? 2'd2 : 2'd0, w_m_a ? 2'd1 : w_w_a ? 2'd2 : 2'd0};
  assign flush_d   = flush;
  assign flush_e   = flush || w_lu;
  assign stall_f   = !flush && w_lu;
  assign stall_d   = !flush && w_lu;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_w <= {r_m.valid, r_m.rd, r_m.reg_wr};
      r_m <= {r_e.valid, r_e.rd, r_e.reg_wr, r_e.load};
      r_e <= {valid_d && !flush_e, rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_d, reg_wr_d, load_d};
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= perf_clr ? '0 : (stall_d && stall_cnt != '1) ? stall_cnt + 32'd1 : stall_cnt;
      flush_cnt <= perf_clr ? '0 : (flush && flush_cnt != '1) ? flush_cnt + 32'd1 : flush_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed test-plan scenarios plus random instruction streams against a stage-list model.
module tb_hazard_control;
  logic        clk = 0, rst_n = 0;
  logic        valid_d = 0, rs1_used_d = 0, rs2_used_d = 0, reg_wr_d = 0, load_d = 0, flush = 0;
  logic [4:0]  rs1_d = 0, rs2_d = 0, rd_d = 0;
  logic [3:0]  fwd_sel_e;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic        perf_clr = 0;
  logic [31:0] stall_cnt, flush_cnt;
  int          n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  hazard_control dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d), .rd_d(rd_d), .reg_wr_d(reg_wr_d),
    .load_d(load_d), .flush(flush), .fwd_sel_e(fwd_sel_e), .stall_f(stall_f),
    .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e)
`ifdef HAZARD_PERF_EN
    , .perf_clr(perf_clr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );
`ifndef HAZARD_PERF_EN
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
  typedef struct {
    bit       v;
    bit [4:0] rs1, rs2;
    bit       u1, u2;
    bit [4:0] rd;
    bit       wr, ld;
  } ins_t;
  ins_t        stg[3];
  bit   [31:0] m_stall = 0, m_flush = 0;
  bit          last_stall;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic ins_t mk(bit v, bit [4:0] rs1, bit [4:0] rs2, bit u1, bit u2, bit [4:0] rd, bit wr, bit ld);
    ins_t i;
    i.v = v; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2; i.rd = rd; i.wr = wr; i.ld = ld;
    return i;
  endfunction
  function automatic bit writes(ins_t x, bit [4:0] r);
    return x.v && x.wr && x.rd == r && r != 0;
  endfunction
  function automatic bit m_lu(ins_t d);
    return d.v && stg[0].v && stg[0].ld && ((d.u1 && writes(stg[0], d.rs1)) || (d.u2 && writes(stg[0], d.rs2)));
  endfunction
  function automatic bit [1:0] m_sel(bit used, bit [4:0] r);
    if (!(stg[0].v && used)) return 0;
    if (writes(stg[1], r) && !stg[1].ld) return 1;
    if (writes(stg[2], r)) return 2;
    return 0;
  endfunction
  task automatic model_reset();
    for (int s = 0; s < 3; s++) stg[s] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    m_stall = 0;
    m_flush = 0;
  endtask
  task automatic apply(input ins_t i, input bit fl);
    bit lu, fe;
    @(negedge clk);
    valid_d = i.v; rs1_d = i.rs1; rs2_d = i.rs2; rs1_used_d = i.u1; rs2_used_d = i.u2;
    rd_d = i.rd; reg_wr_d = i.wr; load_d = i.ld; flush = fl;
    #1;
    lu = m_lu(i);
    fe = fl || lu;
    chk("flush_d", 32'(flush_d), 32'(fl));
    chk("flush_e", 32'(flush_e), 32'(fe));
    chk("stall_f", 32'(stall_f), 32'(!fl && lu));
    chk("stall_d", 32'(stall_d), 32'(!fl && lu));
    chk("fwd_sel_e", 32'(fwd_sel_e), 32'({m_sel(stg[0].u2, stg[0].rs2), m_sel(stg[0].u1, stg[0].rs1)}));
`ifdef HAZARD_PERF_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
`endif
    m_stall = perf_clr ? 0 : (!fl && lu && m_stall != '1) ? m_stall + 1 : m_stall;
    m_flush = perf_clr ? 0 : (fl && m_flush != '1) ? m_flush + 1 : m_flush;
    stg[2] = stg[1];
    stg[1] = stg[0];
    stg[0] = i;
    stg[0].v = i.v && !fe;
    last_stall = !fl && lu;
  endtask
  ins_t nop, cur;
  bit   fl, stalled;
  initial begin
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_fwd", 32'(fwd_sel_e), 0);
    chk("rst_ctl", 32'({stall_f, stall_d, flush_d, flush_e}), 0);
    rst_n = 1;
    // ALU chain: writer in M forwards to the reader in E
    apply(mk(1, 1, 2, 1, 1, 5, 1, 0), 0);
    apply(mk(1, 5, 0, 1, 0, 6, 1, 0), 0);
    apply(nop, 0);
    chk("alu_chain", 32'(fwd_sel_e), 32'h1);
    chk("alu_nostall", 32'(stall_d), 0);
    // two producers of x7: the newer one in M wins
    apply(mk(1, 1, 1, 1, 0, 7, 1, 0), 0);
    apply(mk(1, 2, 2, 1, 0, 7, 1, 0), 0);
    apply(mk(1, 0, 7, 0, 1, 8, 1, 0), 0);
    apply(nop, 0);
    chk("double_prod", 32'(fwd_sel_e), 32'h4);
    // load-use: one stall cycle, then both operands from W
    perf_clr = 1;
    apply(nop, 0);
    perf_clr = 0;
    apply(mk(1, 1, 0, 1, 0, 3, 1, 1), 0);
    apply(mk(1, 3, 3, 1, 1, 9, 1, 0), 0);
    chk("lu_stall", 32'({stall_f, stall_d, flush_e, flush_d}), 32'hE);
    apply(mk(1, 3, 3, 1, 1, 9, 1, 0), 0);
    chk("lu_one_cycle", 32'(stall_d), 0);
    apply(nop, 0);
    chk("lu_fwd", 32'(fwd_sel_e), 32'hA);
`ifdef HAZARD_PERF_EN
    chk("lu_cnt", stall_cnt, 1);
`endif
    // flush dominates a simultaneous load-use
    apply(mk(1, 1, 0, 1, 0, 3, 1, 1), 0);
    apply(mk(1, 3, 0, 1, 0, 4, 1, 0), 1);
    chk("fl_lu", 32'({stall_f, stall_d, flush_d, flush_e}), 32'h3);
    apply(nop, 0);
    chk("fl_bubble", 32'(fwd_sel_e), 0);
    // x0 never stalls or forwards; an unused rs2 never stalls
    apply(mk(1, 1, 0, 1, 0, 0, 1, 1), 0);
    apply(mk(1, 0, 0, 1, 1, 2, 1, 0), 0);
    chk("x0_nostall", 32'(stall_d), 0);
    apply(nop, 0);
    chk("x0_fwd", 32'(fwd_sel_e), 0);
    apply(mk(1, 1, 0, 1, 0, 4, 1, 1), 0);
    apply(mk(1, 1, 4, 1, 0, 2, 1, 0), 0);
    chk("rs2_unused", 32'(stall_d), 0);
    // random streams; Decode holds its instruction while stalled
    stalled = 0;
    repeat (600) begin
      if (!stalled)
        cur = mk($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0);
      fl = $urandom_range(0, 9) == 0;
      perf_clr = $urandom_range(0, 59) == 0;
      apply(cur, fl);
      perf_clr = 0;
      stalled = last_stall;
    end
    // reset asserted mid-stall
    apply(mk(1, 1, 0, 1, 0, 3, 1, 1), 0);
    apply(mk(1, 3, 0, 1, 0, 5, 1, 0), 0);
    chk("pre_rst_stall", 32'(stall_d), 1);
    rst_n = 0;
    #1;
    chk("rst_mid_ctl", 32'({stall_f, stall_d, flush_d, flush_e}), 0);
    chk("rst_mid_fwd", 32'(fwd_sel_e), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    apply(mk(0, 3, 3, 1, 1, 5, 1, 0), 0);
    chk("post_rst_ctl", 32'({stall_f, stall_d, flush_d, flush_e}), 0);
    chk("post_rst_fwd", 32'(fwd_sel_e), 0);
    chk("post_rst_cnt", stall_cnt | flush_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_control.md
# hazard_control

Pipeline hazard controller for the five-stage core. It tracks the destination register of the instructions in the Execute, Memory and Writeback stages and drives the forwarding select of the execute stage. It detects load-use hazards and responds by stalling Fetch/Decode and inserting a bubble into Execute. It also turns the execute-stage `flush` (taken branch or jump) into Decode/Execute kill signals.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid_d` in 1: Decode holds a real instruction.
- `rs1_d`, `rs2_d` in 5 each: Decode source register indices.
- `rs1_used_d`, `rs2_used_d` in 1 each: the instruction reads that source.
- `rd_d` in 5: Decode destination register index.
- `reg_wr_d` in 1: the instruction writes `rd_d`.
- `load_d` in 1: the result comes from data memory.
- `flush` in 1: redirect from the execute stage, valid in the same cycle.
- `fwd_sel_e` out 4: `[1:0]` selects the A operand, `[3:2]` selects the B operand.
  - 0: register file value.
  - 1: `exec_res_m`.
  - 2: `reg_d_w`.
  - 3: never driven.
- `stall_f` out 1: hold the PC register.
- `stall_d` out 1: hold the F/D register.
- `flush_d` out 1: clear the F/D register.
- `flush_e` out 1: load a bubble into the D/E register.
- `perf_clr` in 1 (HAZARD_PERF_EN only): synchronous counter clear.
- `stall_cnt`, `flush_cnt` out 32 each (HAZARD_PERF_EN only): event counters.

## Operation
- Three internal stage records:
  - E: {valid, rs1, rs2, rs1_used, rs2_used, rd, reg_wr, load}.
  - M: {valid, rd, reg_wr, load}.
  - W: {valid, rd, reg_wr}.
- An entry "writes r" when all of the following hold: valid, reg_wr, rd == r, r != 0.
- Load-use hazard `lu`: all of the following hold.
  - E.valid and E.load.
  - E writes a source that Decode reads: `rs1_used_d` and `rs1_d` == E.rd, or `rs2_used_d` and `rs2_d` == E.rd.
  - `valid_d`.
- Output rules:
  - `flush`=1: `flush_d`=1, `flush_e`=1, `stall_f`=0, `stall_d`=0. Flush dominates `lu`.
  - `flush`=0 and `lu`=1: `stall_f`=1, `stall_d`=1, `flush_e`=1, `flush_d`=0.
  - Otherwise all four are 0.
- Record update at each rising edge:
  - W ← M.
  - M ← E fields.
  - E ← Decode inputs, with E.valid = `valid_d` and not `flush_e`.
- Forwarding per operand, evaluated with r = E.rs1 for A and r = E.rs2 for B:
  - If the operand is used and M writes r and M.load=0: select 1.
  - Else if the operand is used and W writes r: select 2.
  - Else: select 0.
  - M is the newest producer and wins over W.
- A load in M matching an E source never selects 1. The preceding `lu` stall guarantees the value is available in W one cycle later.
- Register x0 never forwards and never stalls.

## Timing
- All outputs are combinational from the registered records and the current Decode inputs. There are no extra latency stages.
- A load-use hazard costs exactly one stall cycle:
  - The cycle after `lu`, E holds a bubble, so `lu`=0.
  - The consumer enters E one cycle later with the load in W and gets select 2.
- `flush` has zero-cycle latency. The kill applies at the same edge as the redirect.
- Reset (async assert, released synchronously to `clk` by the reset tree):
  - All record valid bits are 0.
  - `fwd_sel_e`=0, `stall_f`=0, `stall_d`=0, `flush_d`=0, `flush_e`=0.
  - Counters are 0.
- Reset asserted mid-stall discards the pending stall. The first cycle after release always has `lu`=0.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `perf_clr`, `stall_cnt` and `flush_cnt` exist.
  - `stall_cnt` increments on every cycle with `stall_d`=1.
  - `flush_cnt` increments on every cycle with `flush`=1.
  - Both saturate at 0xFFFF_FFFF.
  - `perf_clr` sets both to 0 and has priority over increment.
- `HAZARD_PERF_EN` undefined: the three ports and both counters are absent. Hazard behaviour is identical.

## Test plan
- ALU chain: x5 written (reg_wr=1, load=0) by instruction N, then N+1 reads x5 as rs1 → when N+1 is in E, `fwd_sel_e`=4'b0001, no stall.
- Double producer: N and N+1 both write x7, N+2 reads x7 as rs2 → when N+2 is in E, `fwd_sel_e`=4'b0100 (M beats W).
- Load-use: load to x3, next instruction uses x3 as rs1 and rs2.
  - Exactly one cycle of `stall_f`=`stall_d`=`flush_e`=1.
  - Then `fwd_sel_e`=4'b1010.
  - With HAZARD_PERF_EN, `stall_cnt`=1.
- Flush with simultaneous `lu`: `flush`=1 in the same cycle → `flush_d`=`flush_e`=1 and `stall_f`=`stall_d`=0. The next cycle has E.valid=0 and `fwd_sel_e`=0.
- x0 and unused operands:
  - A load to x0 followed by a read of x0 → no stall, select 0.
  - rs2_used_d=0 with a matching rs2 → no stall.
- Reset mid-stall: drop `rst_n` during a `lu` cycle → all outputs 0 immediately. After release with `valid_d`=0, all outputs stay 0 and the counters read 0.
